// File: rtl/regsel_pkg.sv
`default_nettype none
// ============================================================================
// regsel_pkg
// Shared defaults and types for the register-select scoreboard.
// Revision: 1.0
// ============================================================================
package regsel_pkg;

  localparam int DEFAULT_ADDR_W   = 5;
  localparam int DEFAULT_ZERO_REG = 31;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;

endpackage : regsel_pkg
`default_nettype wire

// File: rtl/regsel_decoder_n.sv
`default_nettype none
// ============================================================================
// decoder_n
// ADDR_W-to-2**ADDR_W combinational one-hot decoder with enable.
// All outputs are zero when en is low.
// Revision: 1.0
// ============================================================================
module decoder_n
  import regsel_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                   en,
  input  logic [ADDR_W-1:0]      addr,
  output logic [(1<<ADDR_W)-1:0] onehot
);

  localparam int N = 1 << ADDR_W;

  // One comparator per output bit; at most one bit matches the address.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign onehot[i] = en && (addr == ADDR_W'(i));
  end

endmodule : decoder_n
`default_nettype wire

// File: rtl/regsel_scoreboard.sv
`default_nettype none
// ============================================================================
// regsel_scoreboard
// Register-destination scoreboard: tracks pending writes per register,
// reports source hazards with same-cycle writeback bypass, generates a
// registered one-hot register-file write enable and a sticky error flag
// for writebacks to registers that were never reserved.
// Revision: 1.0
// ============================================================================
module regsel_scoreboard
  import regsel_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NREG     = 2**ADDR_W,
  parameter int ZERO_REG = DEFAULT_ZERO_REG
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              hazard1,
  output logic              hazard2,
  input  logic              flush,
  output logic [NREG-1:0]   wr_en,
  output logic [NREG-1:0]   busy,
  output logic [ADDR_W:0]   busy_count,
  output logic              err_spurious
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic            issue_is_zero;
  logic            wb_is_zero;
  logic            wb_hits_issue;
  logic            set_en;
  logic            wr_dec_en;
  logic            spurious;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] wr_vec;
  logic [NREG-1:0] busy_nxt;
  logic [NREG-1:0] wr_en_nxt;
  logic [ADDR_W:0] count_nxt;

  // Issue acceptance: free register, freed this cycle by writeback, or the zero register.
  always_comb begin
    issue_is_zero = (issue_rd == ZERO_ADDR);
    wb_is_zero    = (wb_rd == ZERO_ADDR);
    wb_hits_issue = wb_valid && (wb_rd == issue_rd) && !flush;
    issue_ready   = !flush && (!busy[issue_rd] || wb_hits_issue || issue_is_zero);
    set_en        = issue_valid && issue_ready && !issue_is_zero;
    wr_dec_en     = wb_valid && !wb_is_zero && !flush;
    spurious      = wb_valid && !wb_is_zero && !flush && !busy[wb_rd];
  end

  // Source hazards, bypassed when the register is being written back this cycle.
  always_comb begin
    hazard1 = busy[rs1] && !(wb_valid && (wb_rd == rs1)) && (rs1 != ZERO_ADDR);
    hazard2 = busy[rs2] && !(wb_valid && (wb_rd == rs2)) && (rs2 != ZERO_ADDR);
  end

  decoder_n #(.ADDR_W(ADDR_W)) u_dec_set (
    .en     (set_en),
    .addr   (issue_rd),
    .onehot (set_vec)
  );

  decoder_n #(.ADDR_W(ADDR_W)) u_dec_clr (
    .en     (wb_valid),
    .addr   (wb_rd),
    .onehot (clr_vec)
  );

  decoder_n #(.ADDR_W(ADDR_W)) u_dec_wr (
    .en     (wr_dec_en),
    .addr   (wb_rd),
    .onehot (wr_vec)
  );

  // Next busy state: clear then set (set wins on the same register), flush empties all.
  always_comb begin
    busy_nxt  = '0;
    wr_en_nxt = '0;
    if (!flush) begin
      busy_nxt  = (busy & ~clr_vec) | set_vec;
      wr_en_nxt = wr_vec;
    end
    busy_nxt[ZERO_REG] = 1'b0;
  end

  // Popcount of the next busy vector so the count registers alongside busy.
  always_comb begin
    count_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      count_nxt = count_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end
  end

  // State registers with immediate clear on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy         <= '0;
      wr_en        <= '0;
      busy_count   <= '0;
      err_spurious <= 1'b0;
    end else begin
      busy         <= busy_nxt;
      wr_en        <= wr_en_nxt;
      busy_count   <= count_nxt;
      err_spurious <= err_spurious | spurious;
    end
  end

endmodule : regsel_scoreboard
`default_nettype wire

// File: tb/tb_regsel_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_regsel_scoreboard
// Table-driven self-checking bench with an expected-result queue.
// Revision: 1.0
// ============================================================================
module tb_regsel_scoreboard;
  import regsel_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        issue_valid = 1'b0;
  reg_addr_t   issue_rd = '0;
  logic        issue_ready;
  logic        wb_valid = 1'b0;
  reg_addr_t   wb_rd = '0;
  reg_addr_t   rs1 = '0;
  reg_addr_t   rs2 = '0;
  logic        hazard1, hazard2;
  logic        flush = 1'b0;
  logic [31:0] wr_en, busy;
  logic [5:0]  busy_count;
  logic        err_spurious;

  int n_checks = 0;
  int n_fail   = 0;

  regsel_scoreboard dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .hazard1      (hazard1),
    .hazard2      (hazard2),
    .flush        (flush),
    .wr_en        (wr_en),
    .busy         (busy),
    .busy_count   (busy_count),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  ird;
    logic        wv;
    logic [4:0]  wrd;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        fl;
    logic        e_ready;
    logic        e_h1;
    logic        e_h2;
    logic [31:0] e_busy;
    logic [31:0] e_wr;
    logic [5:0]  e_cnt;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [31:0] busy;
    logic [31:0] wr;
    logic [5:0]  cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[14];

  function automatic vec_t mk(logic iv, logic [4:0] ird, logic wv, logic [4:0] wrd,
                              logic [4:0] s1, logic [4:0] s2, logic fl,
                              logic r, logic h1, logic h2, logic [31:0] b,
                              logic [31:0] w, logic [5:0] c, logic e);
    vec_t v;
    v.iv = iv; v.ird = ird; v.wv = wv; v.wrd = wrd; v.s1 = s1; v.s2 = s2; v.fl = fl;
    v.e_ready = r; v.e_h1 = h1; v.e_h2 = h2;
    v.e_busy = b; v.e_wr = w; v.e_cnt = c; v.e_err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_regs(input string tag, input exp_t e);
    chk({tag, " busy"},       busy,         e.busy);
    chk({tag, " wr_en"},      wr_en,        e.wr);
    chk({tag, " busy_count"}, 32'(busy_count), 32'(e.cnt));
    chk({tag, " err"},        32'(err_spurious), 32'(e.err));
  endtask

  // Drive one vector, check combinational outputs, queue the post-edge
  // expectation and compare it once the edge has produced the result.
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    issue_valid = v.iv; issue_rd = v.ird;
    wb_valid = v.wv; wb_rd = v.wrd;
    rs1 = v.s1; rs2 = v.s2; flush = v.fl;
    #1;
    chk({tag, " issue_ready"}, 32'(issue_ready), 32'(v.e_ready));
    chk({tag, " hazard1"},     32'(hazard1),     32'(v.e_h1));
    chk({tag, " hazard2"},     32'(hazard2),     32'(v.e_h2));
    e.busy = v.e_busy; e.wr = v.e_wr; e.cnt = v.e_cnt; e.err = v.e_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s scoreboard: queue empty", tag);
    end else begin
      got = exp_q.pop_front();
      chk_regs(tag, got);
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rd = '0; wb_valid = 1'b0; wb_rd = '0;
    rs1 = '0; rs2 = '0; flush = 1'b0;
  endtask

  exp_t zero_e;

  initial begin
    zero_e.busy = '0; zero_e.wr = '0; zero_e.cnt = '0; zero_e.err = 1'b0;

    //            iv ird wv wrd s1  s2  fl  rdy h1 h2 busy          wr            cnt err
    tbl[0]  = mk(1, 3,  0, 0,  3,  0,  0,  1,  0, 0, 32'h0000_0008, 32'h0,        1, 0);
    tbl[1]  = mk(1, 3,  0, 0,  3,  0,  0,  0,  1, 0, 32'h0000_0008, 32'h0,        1, 0);
    tbl[2]  = mk(0, 3,  1, 3,  3,  0,  0,  1,  0, 0, 32'h0,         32'h0000_0008, 0, 0);
    tbl[3]  = mk(1, 5,  0, 0,  0,  0,  0,  1,  0, 0, 32'h0000_0020, 32'h0,        1, 0);
    tbl[4]  = mk(1, 5,  1, 5,  5,  5,  0,  1,  0, 0, 32'h0000_0020, 32'h0000_0020, 1, 0);
    tbl[5]  = mk(1, 31, 1, 31, 31, 5,  0,  1,  0, 1, 32'h0000_0020, 32'h0,        1, 0);
    tbl[6]  = mk(1, 1,  1, 5,  1,  5,  0,  1,  0, 0, 32'h0000_0002, 32'h0000_0020, 1, 0);
    tbl[7]  = mk(1, 2,  0, 0,  1,  0,  0,  1,  1, 0, 32'h0000_0006, 32'h0,        2, 0);
    tbl[8]  = mk(1, 4,  0, 0,  2,  4,  0,  1,  1, 0, 32'h0000_0016, 32'h0,        3, 0);
    tbl[9]  = mk(1, 7,  1, 2,  2,  4,  1,  0,  0, 1, 32'h0,         32'h0,        0, 0);
    tbl[10] = mk(0, 7,  1, 7,  0,  0,  0,  1,  0, 0, 32'h0,         32'h0000_0080, 0, 1);
    tbl[11] = mk(0, 0,  0, 0,  0,  0,  0,  1,  0, 0, 32'h0,         32'h0,        0, 1);
    tbl[12] = mk(1, 9,  0, 0,  9,  0,  0,  1,  0, 0, 32'h0000_0200, 32'h0,        1, 1);
    tbl[13] = mk(1, 12, 0, 0,  9,  31, 0,  1,  1, 0, 32'h0000_1200, 32'h0,        2, 1);

    // Power-on reset: create a falling edge, check values before any clock edge.
    #2 reset_n = 1'b0;
    #1 chk_regs("reset_async", zero_e);
    repeat (2) @(posedge clk);
    #1 chk_regs("reset_held", zero_e);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Third reservation, then async reset mid-operation with a writeback pending.
    run_vec(mk(1, 20, 0, 0, 20, 0, 0, 1, 0, 0, 32'h0010_1200, 32'h0, 3, 1), 14);
    @(negedge clk);
    idle_inputs();
    wb_valid = 1'b1; wb_rd = 5'd9;
    #1 reset_n = 1'b0;
    #1 chk_regs("midreset_async", zero_e);
    @(posedge clk);
    #1 chk_regs("midreset_edge", zero_e);
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
    @(posedge clk);
    #1 chk_regs("post_reset", zero_e);

    // Reservation of 9 was discarded by reset, so this writeback is spurious.
    run_vec(mk(0, 0, 1, 9, 9, 0, 0, 1, 0, 0, 32'h0, 32'h0000_0200, 0, 1), 15);

    @(negedge clk);
    idle_inputs();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_regsel_scoreboard
`default_nettype wire
